// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding and geometry helpers for the associative data cache.
package dcache_pkg;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    function automatic bit is_pow2(int n);
        return n > 0 && (n & (n - 1)) == 0;
    endfunction

    function automatic bit params_ok(int ways, int line_words, int num_sets);
        return (ways == 1 || ways == 2) && line_words >= 2 && is_pow2(line_words) && is_pow2(num_sets);
    endfunction

    function automatic int offset_w(int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_w(int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_w(int word_size, int line_words, int num_sets);
        return word_size - $clog2(line_words) - $clog2(num_sets);
    endfunction

endpackage

// File: rtl/dcache_way.sv
// dcache_way: valid/tag/data storage for one cache way with combinational lookup.
module dcache_way #(
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4,
    parameter int NUM_SETS   = 4,
    parameter int TAG_W      = 12,
    localparam int OW = $clog2(LINE_WORDS),
    localparam int IW = NUM_SETS > 1 ? $clog2(NUM_SETS) : 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [IW-1:0]                   idx,
    input  logic [TAG_W-1:0]                tag,
    input  logic [OW-1:0]                   offset,
    output logic                            vld,
    output logic                            hit,
    output logic [WORD_SIZE-1:0]            rword,
    input  logic                            line_we,
    input  logic [LINE_WORDS*WORD_SIZE-1:0] line,
    input  logic                            word_we,
    input  logic [WORD_SIZE-1:0]            wdata
);

    logic [NUM_SETS-1:0]                        valid;
    logic [TAG_W-1:0]                           tags [NUM_SETS];
    logic [LINE_WORDS-1:0][WORD_SIZE-1:0]       data [NUM_SETS];

    assign vld   = valid[idx];
    assign hit   = vld && tags[idx] == tag;
    assign rword = data[idx][offset];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            valid <= '0;
        else if (line_we)
            valid[idx] <= 1'b1;
    end

    // Tag and data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tags[idx] <= tag;
            data[idx] <= line;
        end else if (word_we) begin
            data[idx][offset] <= wdata;
        end
    end

endmodule

// File: rtl/dcache_assoc.sv
// dcache_assoc: parametrised write-through, no-write-allocate cache with LRU replacement and hit/miss counters.
module dcache_assoc import dcache_pkg::*; #(
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4,
    parameter int NUM_SETS   = 4,
    parameter int WAYS       = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            readC,
    input  logic                            writeC,
    input  logic [WORD_SIZE-1:0]            address,
    input  logic [WORD_SIZE-1:0]            data_in,
    output logic [WORD_SIZE-1:0]            data_out,
    output logic                            readyC,
    output logic                            readM,
    output logic                            writeM,
    output logic [WORD_SIZE-1:0]            addressM,
    input  logic [LINE_WORDS*WORD_SIZE-1:0] dataM_in,
    output logic [WORD_SIZE-1:0]            dataM_out,
    input  logic                            readyM,
    input  logic                            doneM,
    output logic [WORD_SIZE-1:0]            num_hit,
    output logic [WORD_SIZE-1:0]            num_miss
);

    localparam int OFFSET_W = offset_w(LINE_WORDS);
    localparam int INDEX_W  = index_w(NUM_SETS);
    localparam int TAG_W    = tag_w(WORD_SIZE, LINE_WORDS, NUM_SETS);
    localparam int IDX_W    = INDEX_W > 0 ? INDEX_W : 1;

    if (!params_ok(WAYS, LINE_WORDS, NUM_SETS)) begin : g_bad_params
        $error("dcache_assoc: illegal WAYS/LINE_WORDS/NUM_SETS");
    end

    state_t                         state;
    logic [WORD_SIZE-1:0]           addr_q, lk_addr;
    logic [IDX_W-1:0]               idx;
    logic [TAG_W-1:0]               tag;
    logic [OFFSET_W-1:0]            off;
    logic [WAYS-1:0]                hit, vld;
    logic [WAYS-1:0][WORD_SIZE-1:0] rword;
    logic [NUM_SETS-1:0]            lru;
    logic                           hit_any, hit_way, victim, replay, rd_hit, fill_done, write_done;

    // Outside IDLE the lookup runs on the latched request so the CPU may move on.
    assign lk_addr = state == IDLE ? address : addr_q;
    assign tag     = lk_addr[WORD_SIZE-1 -: TAG_W];
    assign off     = lk_addr[OFFSET_W-1:0];

    if (INDEX_W == 0) begin : g_one_set
        assign idx = '0;
    end else begin : g_sets
        assign idx = lk_addr[OFFSET_W +: INDEX_W];
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        dcache_way #(
            .WORD_SIZE(WORD_SIZE), .LINE_WORDS(LINE_WORDS), .NUM_SETS(NUM_SETS), .TAG_W(TAG_W)
        ) u_way (
            .clk(clk), .reset_n(reset_n), .idx(idx), .tag(tag), .offset(off),
            .vld(vld[w]), .hit(hit[w]), .rword(rword[w]),
            .line_we(fill_done && victim == 1'(w)), .line(dataM_in),
            .word_we(write_done && hit[w]), .wdata(dataM_out)
        );
    end

    assign hit_any    = |hit;
    assign hit_way    = (WAYS == 2) && hit[WAYS-1];
    assign victim     = (WAYS == 2) && vld[0] && (!vld[WAYS-1] || lru[idx]);
    assign rd_hit     = state == IDLE && readC && !writeC && hit_any;
    assign fill_done  = state == FILL && readyM;
    assign write_done = state == WRITE && doneM;
    assign readyC     = rd_hit || write_done;
    assign data_out   = rd_hit ? rword[hit_way] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            readM     <= 1'b0;
            writeM    <= 1'b0;
            addressM  <= '0;
            dataM_out <= '0;
            addr_q    <= '0;
            lru       <= '0;
            replay    <= 1'b0;
            num_hit   <= '0;
            num_miss  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    replay <= 1'b0;
                    if (writeC) begin
                        state     <= WRITE;
                        writeM    <= 1'b1;
                        addressM  <= address;
                        dataM_out <= data_in;
                        addr_q    <= address;
                    end else if (readC && hit_any) begin
                        lru[idx] <= ~hit_way;
                        if (!replay)
                            num_hit <= num_hit + WORD_SIZE'(1);
                    end else if (readC) begin
                        state    <= FILL;
                        readM    <= 1'b1;
                        addressM <= {address[WORD_SIZE-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        addr_q   <= address;
                    end
                end
                FILL: if (readyM) begin
                    state    <= IDLE;
                    readM    <= 1'b0;
                    lru[idx] <= ~victim;
                    replay   <= 1'b1;
                    num_miss <= num_miss + WORD_SIZE'(1);
                end
                WRITE: if (doneM) begin
                    state  <= IDLE;
                    writeM <= 1'b0;
                    if (hit_any) begin
                        lru[idx] <= ~hit_way;
                        num_hit  <= num_hit + WORD_SIZE'(1);
                    end else begin
                        num_miss <= num_miss + WORD_SIZE'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: directed bench for dcache_assoc, default 2-way build plus a 1-way build.
module tb_dcache_assoc;

    logic        clk = 0, reset_n = 0, readC = 0, writeC = 0, readyM = 0, doneM = 0;
    logic [15:0] address = 0, data_in = 0;
    logic [63:0] dataM_in = 0;
    logic        sel = 0;
    int          checks = 0, errors = 0, rm_total = 0;
    logic [15:0] fill_addr = 0;

    logic [15:0] do0, am0, dm0, nh0, nm0, do1, am1, dm1, nh1, nm1;
    logic        rc0, rm0, wm0, rc1, rm1, wm1;
    logic [15:0] data_out, addressM, dataM_out, num_hit, num_miss;
    logic        readyC, readM, writeM;

    localparam logic [63:0] L1 = 64'h4444_3333_2222_1111;
    localparam logic [63:0] L2 = 64'h2003_2002_2001_2000;
    localparam logic [63:0] LA = 64'hA003_A002_A001_A000;
    localparam logic [63:0] LB = 64'hB003_B002_B001_B000;
    localparam logic [63:0] LC = 64'hC003_C002_C001_C000;

    always #5 clk = ~clk;

    dcache_assoc dut0 (
        .clk(clk), .reset_n(reset_n), .readC(readC), .writeC(writeC), .address(address), .data_in(data_in),
        .data_out(do0), .readyC(rc0), .readM(rm0), .writeM(wm0), .addressM(am0), .dataM_in(dataM_in),
        .dataM_out(dm0), .readyM(readyM), .doneM(doneM), .num_hit(nh0), .num_miss(nm0)
    );

    dcache_assoc #(.WAYS(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .readC(readC), .writeC(writeC), .address(address), .data_in(data_in),
        .data_out(do1), .readyC(rc1), .readM(rm1), .writeM(wm1), .addressM(am1), .dataM_in(dataM_in),
        .dataM_out(dm1), .readyM(readyM), .doneM(doneM), .num_hit(nh1), .num_miss(nm1)
    );

    assign data_out  = sel ? do1 : do0;
    assign addressM  = sel ? am1 : am0;
    assign dataM_out = sel ? dm1 : dm0;
    assign num_hit   = sel ? nh1 : nh0;
    assign num_miss  = sel ? nm1 : nm0;
    assign readyC    = sel ? rc1 : rc0;
    assign readM     = sel ? rm1 : rm0;
    assign writeM    = sel ? wm1 : wm0;

    always @(posedge clk) begin
        if (readM) rm_total++;
        if (reset_n) assert (!(readC && writeC)) else $error("readC and writeC raised together");
        assert (!(rm0 && wm0)) else $error("readM and writeM high together");
    end

    task automatic rd(input logic [15:0] a, input logic [63:0] line, output logic [15:0] d, output int lat);
        int rm = 0;
        lat = -1;
        d = 'x;
        @(negedge clk);
        readC = 1;
        address = a;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (readyC) begin
                d = data_out;
                lat = c;
                break;
            end
            if (readM) begin
                rm++;
                fill_addr = addressM;
                if (rm == 3) begin
                    readyM = 1;
                    dataM_in = line;
                end
            end
            @(negedge clk);
            readyM = 0;
        end
        @(negedge clk);
        readC = 0;
        readyM = 0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, output int lat, output logic [15:0] wa, output logic [15:0] wd);
        int wm = 0;
        lat = -1;
        wa = 'x;
        wd = 'x;
        @(negedge clk);
        writeC = 1;
        address = a;
        data_in = d;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (writeM) begin
                wm++;
                wa = addressM;
                wd = dataM_out;
                if (wm == 2) doneM = 1;
            end
            #1;
            if (readyC) begin
                lat = c;
                break;
            end
            @(negedge clk);
            doneM = 0;
        end
        @(negedge clk);
        writeC = 0;
        doneM = 0;
        data_in = 16'h0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (readyC !== 1'b0) begin errors++; $display("FAIL reset_readyC got %b exp 0", readyC); end
        checks++; if (readM !== 1'b0) begin errors++; $display("FAIL reset_readM got %b exp 0", readM); end
        checks++; if (writeM !== 1'b0) begin errors++; $display("FAIL reset_writeM got %b exp 0", writeM); end
        checks++; if (addressM !== 16'h0) begin errors++; $display("FAIL reset_addressM got %h exp 0000", addressM); end
        checks++; if (dataM_out !== 16'h0) begin errors++; $display("FAIL reset_dataM_out got %h exp 0000", dataM_out); end
        checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL reset_data_out got %h exp 0000", data_out); end
        checks++; if (num_hit !== 16'h0) begin errors++; $display("FAIL reset_num_hit got %0d exp 0", num_hit); end
        checks++; if (num_miss !== 16'h0) begin errors++; $display("FAIL reset_num_miss got %0d exp 0", num_miss); end
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_cold_read();
        logic [15:0] d;
        int lat, rm_before;
        rd(16'h0013, L1, d, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL cold_latency got %0d exp 4", lat); end
        checks++; if (d !== 16'h4444) begin errors++; $display("FAIL cold_data got %h exp 4444", d); end
        checks++; if (fill_addr !== 16'h0010) begin errors++; $display("FAIL cold_fill_addr got %h exp 0010", fill_addr); end
        checks++; if (num_miss !== 16'd1) begin errors++; $display("FAIL cold_num_miss got %0d exp 1", num_miss); end
        checks++; if (num_hit !== 16'd0) begin errors++; $display("FAIL cold_replay_hit got %0d exp 0", num_hit); end
        rm_before = rm_total;
        rd(16'h0011, L1, d, lat);
        checks++; if (lat !== 0) begin errors++; $display("FAIL hit_latency got %0d exp 0", lat); end
        checks++; if (d !== 16'h2222) begin errors++; $display("FAIL hit_data got %h exp 2222", d); end
        checks++; if (num_hit !== 16'd1) begin errors++; $display("FAIL hit_num_hit got %0d exp 1", num_hit); end
        checks++; if (rm_total !== rm_before) begin errors++; $display("FAIL hit_no_readM got %0d exp %0d", rm_total, rm_before); end
    endtask

    task automatic test_write_hit();
        logic [15:0] d, wa, wd;
        int lat;
        wr(16'h0011, 16'hBEEF, lat, wa, wd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_hit_latency got %0d exp 2", lat); end
        checks++; if (wa !== 16'h0011) begin errors++; $display("FAIL wr_hit_addressM got %h exp 0011", wa); end
        checks++; if (wd !== 16'hBEEF) begin errors++; $display("FAIL wr_hit_dataM_out got %h exp beef", wd); end
        checks++; if (num_hit !== 16'd2) begin errors++; $display("FAIL wr_hit_num_hit got %0d exp 2", num_hit); end
        checks++; if (writeM !== 1'b0) begin errors++; $display("FAIL wr_hit_writeM_drop got %b exp 0", writeM); end
        rd(16'h0011, L1, d, lat);
        checks++; if (lat !== 0) begin errors++; $display("FAIL wr_hit_readback_lat got %0d exp 0", lat); end
        checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL wr_hit_readback got %h exp beef", d); end
        checks++; if (num_hit !== 16'd3) begin errors++; $display("FAIL wr_hit_readback_hits got %0d exp 3", num_hit); end
    endtask

    task automatic test_write_miss();
        logic [15:0] d, wa, wd;
        int lat, rm_before;
        rm_before = rm_total;
        wr(16'h0200, 16'h1234, lat, wa, wd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_miss_latency got %0d exp 2", lat); end
        checks++; if (wa !== 16'h0200) begin errors++; $display("FAIL wr_miss_addressM got %h exp 0200", wa); end
        checks++; if (rm_total !== rm_before) begin errors++; $display("FAIL wr_miss_no_fill got %0d exp %0d", rm_total, rm_before); end
        checks++; if (num_miss !== 16'd2) begin errors++; $display("FAIL wr_miss_num_miss got %0d exp 2", num_miss); end
        checks++; if (num_hit !== 16'd3) begin errors++; $display("FAIL wr_miss_num_hit got %0d exp 3", num_hit); end
        rd(16'h0200, L2, d, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL wr_miss_read_lat got %0d exp 4", lat); end
        checks++; if (d !== 16'h2000) begin errors++; $display("FAIL wr_miss_read_data got %h exp 2000", d); end
        checks++; if (num_miss !== 16'd3) begin errors++; $display("FAIL wr_miss_read_miss got %0d exp 3", num_miss); end
    endtask

    task automatic test_lru();
        logic [15:0] d;
        int lat;
        rd(16'h0000, LA, d, lat);
        checks++; if (lat !== 4 || d !== 16'hA000) begin errors++; $display("FAIL lru_a_miss got lat %0d data %h exp 4 a000", lat, d); end
        rd(16'h0040, LB, d, lat);
        checks++; if (lat !== 4 || d !== 16'hB000) begin errors++; $display("FAIL lru_b_miss got lat %0d data %h exp 4 b000", lat, d); end
        rd(16'h0000, LA, d, lat);
        checks++; if (lat !== 0 || d !== 16'hA000) begin errors++; $display("FAIL lru_a_hit got lat %0d data %h exp 0 a000", lat, d); end
        rd(16'h0082, LC, d, lat);
        checks++; if (lat !== 4 || d !== 16'hC002) begin errors++; $display("FAIL lru_c_miss got lat %0d data %h exp 4 c002", lat, d); end
        rd(16'h0003, LA, d, lat);
        checks++; if (lat !== 0 || d !== 16'hA003) begin errors++; $display("FAIL lru_a_kept got lat %0d data %h exp 0 a003", lat, d); end
        rd(16'h0041, LB, d, lat);
        checks++; if (lat !== 4 || d !== 16'hB001) begin errors++; $display("FAIL lru_b_evicted got lat %0d data %h exp 4 b001", lat, d); end
        checks++; if (num_hit !== 16'd5 || num_miss !== 16'd7) begin errors++; $display("FAIL lru_counters got %0d/%0d exp 5/7", num_hit, num_miss); end
    endtask

    task automatic test_reset_mid_fill();
        logic [15:0] d;
        int lat, c;
        @(negedge clk);
        readC = 1;
        address = 16'h0013;
        c = 0;
        do begin
            @(negedge clk);
            #1;
            c++;
        end while (!readM && c < 10);
        checks++; if (readM !== 1'b1) begin errors++; $display("FAIL midfill_readM_up got %b exp 1", readM); end
        reset_n = 0;
        #1;
        checks++; if (readM !== 1'b0) begin errors++; $display("FAIL midfill_readM_drop got %b exp 0", readM); end
        checks++; if (num_hit !== 16'd0 || num_miss !== 16'd0) begin errors++; $display("FAIL midfill_counters got %0d/%0d exp 0/0", num_hit, num_miss); end
        checks++; if (addressM !== 16'h0) begin errors++; $display("FAIL midfill_addressM got %h exp 0000", addressM); end
        readC = 0;
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        readyM = 1;
        dataM_in = L1;
        @(negedge clk);
        readyM = 0;
        #1;
        checks++; if (num_miss !== 16'd0 || readM !== 1'b0 || readyC !== 1'b0) begin errors++; $display("FAIL late_readyM got miss %0d readM %b readyC %b exp 0 0 0", num_miss, readM, readyC); end
        rd(16'h0013, L1, d, lat);
        checks++; if (lat !== 4 || d !== 16'h4444) begin errors++; $display("FAIL refill got lat %0d data %h exp 4 4444", lat, d); end
        checks++; if (num_miss !== 16'd1) begin errors++; $display("FAIL refill_num_miss got %0d exp 1", num_miss); end
    endtask

    task automatic test_ways1();
        logic [15:0] d, exp_d;
        int lat;
        reset_n = 0;
        sel = 1;
        repeat (2) @(negedge clk);
        reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            exp_d = i[0] ? 16'hB000 : 16'hA000;
            rd(i[0] ? 16'h0040 : 16'h0000, i[0] ? LB : LA, d, lat);
            checks++; if (lat !== 4 || d !== exp_d) begin errors++; $display("FAIL ways1_read%0d got lat %0d data %h exp 4 %h", i, lat, d, exp_d); end
        end
        checks++; if (num_hit !== 16'd0) begin errors++; $display("FAIL ways1_num_hit got %0d exp 0", num_hit); end
        checks++; if (num_miss !== 16'd4) begin errors++; $display("FAIL ways1_num_miss got %0d exp 4", num_miss); end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_write_hit();
        test_write_miss();
        test_lru();
        test_reset_mid_fill();
        test_ways1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
